// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, addresses the instruction ROM and
// queues {pc, instr} pairs in a small circular FIFO toward decode.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rd,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] pc;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic full;
    logic push;
    logic pop;
    logic unused_redir_bits;

    assign unused_redir_bits = ^redir_pc[1:0];

    assign imem_addr = {2'b00, pc[WIDTH-1:2]};
    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A full FIFO may still accept a push when its head leaves in the same cycle.
    assign push      = fetch_en & ~redir_valid & (~full | pop);

    assign out_pc    = out_valid ? pc_mem[head]    : '0;
    assign out_instr = out_valid ? instr_mem[head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redir_valid) begin
            pc    <= {redir_pc[WIDTH-1:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc   <= pc + WIDTH'(4);
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= pc;
            instr_mem[tail] <= imem_rd;
        end
    end

endmodule
